// File: rtl/sm4_rkey_buf.sv
// SM4 round-key buffer: captures the 32 expanded round keys once, then replays
// them one per request in encryption (rk0..rk31) or decryption (rk31..rk0) order.
module sm4_rkey_buf #(
    parameter int RKEY_W   = 32,
    parameter int RKEY_NUM = 32
) (
    input  logic              clk_sys,
    input  logic              sys_rst_n,
    input  logic              key_load_start,
    input  logic [RKEY_W-1:0] key2core_rkey,
    input  logic              key2core_rkey_vld,
    input  logic              core_blk_start,
    input  logic              dec_mode,
    input  logic              core_rkey_req,
    output logic [RKEY_W-1:0] rkey_out,
    output logic              rkey_out_vld,
    output logic [4:0]        rkey_out_idx,
    output logic              rkey_out_last,
    output logic              keys_ready,
    output logic              key_err
);
    localparam logic [1:0] EMPTY   = 2'd0;
    localparam logic [1:0] LOADING = 2'd1;
    localparam logic [1:0] READY   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [5:0]        wr_ptr_q, wr_ptr_d;
    logic [4:0]        rd_idx_q, rd_idx_d;
    logic              dec_q, dec_d;
    logic              key_err_q, key_err_d;
    logic [RKEY_W-1:0] rkey_q;
    logic              vld_q;
    logic [4:0]        idx_q;
    logic              last_q;
    logic [RKEY_W-1:0] mem_q [RKEY_NUM];

    logic       wr_en, rd_en, rd_dec;
    logic [4:0] rd_base, rd_addr;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_idx_d  = rd_idx_q;
        dec_d     = dec_q;
        key_err_d = key_err_q;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        rd_base   = rd_idx_q;
        rd_dec    = dec_q;
        if (key_load_start) begin
            // A reload discards whatever beat or request shares its cycle.
            state_d   = LOADING;
            wr_ptr_d  = '0;
            key_err_d = 1'b0;
            rd_idx_d  = '0;
            dec_d     = 1'b0;
        end else begin
            case (state_q)
                LOADING: if (key2core_rkey_vld) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 6'd1;
                    if (wr_ptr_q == 6'(RKEY_NUM - 1)) state_d = READY;
                end
                READY:   if (key2core_rkey_vld) key_err_d = 1'b1;
                default: ;
            endcase
            // Block start is folded in ahead of the read so a same-cycle
            // request fetches round 0 in the freshly sampled mode.
            if (core_blk_start) begin
                rd_base  = '0;
                rd_dec   = dec_mode;
                rd_idx_d = '0;
                dec_d    = dec_mode;
            end
            if (core_rkey_req && state_q == READY) begin
                rd_en    = 1'b1;
                rd_idx_d = rd_base + 5'd1;
            end
        end
        rd_addr = rd_dec ? (5'(RKEY_NUM - 1) - rd_base) : rd_base;
    end

    always_ff @(posedge clk_sys or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= EMPTY;
            wr_ptr_q  <= '0;
            rd_idx_q  <= '0;
            dec_q     <= 1'b0;
            key_err_q <= 1'b0;
            rkey_q    <= '0;
            vld_q     <= 1'b0;
            idx_q     <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_idx_q  <= rd_idx_d;
            dec_q     <= dec_d;
            key_err_q <= key_err_d;
            vld_q     <= rd_en;
            if (rd_en) begin
                rkey_q <= mem_q[rd_addr];
                idx_q  <= rd_base;
                last_q <= (rd_base == 5'(RKEY_NUM - 1));
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (wr_en) mem_q[wr_ptr_q[4:0]] <= key2core_rkey;
    end

    assign rkey_out      = rkey_q;
    assign rkey_out_vld  = vld_q;
    assign rkey_out_idx  = idx_q;
    assign rkey_out_last = last_q;
    assign keys_ready    = (state_q == READY);
    assign key_err       = key_err_q;
endmodule

// File: doc/sm4_rkey_buf.md
# sm4_rkey_buf

Round-key buffer between the SM4 key-expansion stage and the SM4 round core. It captures the 32 round keys rk0..rk31 streamed one per cycle on the key2core_rkey / key2core_rkey_vld bus and stores them. It then replays them to the round core on request, one key per cycle, in encryption order (rk0..rk31) or decryption order (rk31..rk0). Keys are expanded once and reused for every CTR block until a new key is loaded.

## Interface
Parameters:
- RKEY_W, 32, round-key width
- RKEY_NUM, 32, number of round keys; fixed at 32 for SM4

Ports:
- clk_sys  in  1  system clock; all logic on the rising edge
- sys_rst_n  in  1  reset; asynchronous assert, active-low
- key_load_start  in  1  one-cycle pulse, concurrent with the key expander being started; invalidates the stored keys and rewinds the write pointer
- key2core_rkey  in  32  round key from the key expander
- key2core_rkey_vld  in  1  key2core_rkey is valid this cycle
- core_blk_start  in  1  one-cycle pulse; rewinds the read index for a new block and samples dec_mode
- dec_mode  in  1  0 = encryption order, 1 = decryption order; sampled only on core_blk_start
- core_rkey_req  in  1  request one round key this cycle
- rkey_out  out  32  round key delivered to the core
- rkey_out_vld  out  1  rkey_out valid, one-cycle pulse per accepted request
- rkey_out_idx  out  5  round number (0..31) of the delivered key
- rkey_out_last  out  1  high with rkey_out_vld on the 32nd key of a block
- keys_ready  out  1  all 32 keys stored and readable
- key_err  out  1  sticky error: a vld beat arrived after 32 keys were stored; cleared by key_load_start

## Operation
- Storage: 32 x 32-bit array, write pointer wr_ptr[5:0], read index rd_idx[4:0], registered mode bit dec_q.
- States:
  - EMPTY (reset). key_load_start -> LOADING.
  - LOADING. Each vld beat writes mem[wr_ptr], then wr_ptr++. The beat with wr_ptr==31 -> READY.
  - READY. key_load_start -> LOADING.
  - key_load_start in any state: wr_ptr=0, keys_ready=0, key_err=0, rd_idx=0, dec_q=0, go to LOADING.
- A vld beat in EMPTY is ignored.
- A vld beat in READY is not written and sets key_err=1.
- Read, accepted only when state is READY and key_load_start is low:
  - Physical address = rd_idx when dec_q=0; 31-rd_idx when dec_q=1.
  - rkey_out <= mem[address]; rkey_out_idx <= rd_idx; rkey_out_last <= (rd_idx==31).
  - rd_idx++ with modulo-32 wrap, so the next block continues without needing core_blk_start.
- Requests outside READY are dropped silently: no vld, rd_idx unchanged.
- core_blk_start sets rd_idx=0 and dec_q=dec_mode.
- Priorities within one cycle:
  - key_load_start over everything. The same-cycle vld beat and request are discarded.
  - core_blk_start before core_rkey_req. A same-cycle request reads round 0 in the newly sampled mode.
- rkey_out, rkey_out_idx and rkey_out_last hold their last value when rkey_out_vld=0.

## Timing
- Reset values: rkey_out=0, rkey_out_vld=0, rkey_out_idx=0, rkey_out_last=0, keys_ready=0, key_err=0, state EMPTY, wr_ptr=0, rd_idx=0, dec_q=0. Array contents are not reset.
- Write: data is stored at the clock edge that samples the vld beat.
- keys_ready rises the cycle after the 32nd beat is sampled.
- Read latency is 1 cycle: a request at cycle t gives rkey_out_vld at t+1. Full throughput: 32 back-to-back requests give 32 consecutive vld cycles.
- First read: if the 32nd write is sampled at cycle t, a request at t+1 is accepted and its data appears at t+2.
- key_load_start at cycle t: keys_ready=0 from t+1. A request accepted at t-1 still produces its output at t; nothing is output at t+1.
- Reset asserted mid-load or mid-read: outputs clear immediately (asynchronously). After release the block is in EMPTY and needs a fresh key_load_start.

## Test plan
- Load: key_load_start, then 32 beats with rk_i = 0xA5000000+i. Required: keys_ready=1 exactly one cycle after beat 31; key_err=0.
- Encryption read: core_blk_start with dec_mode=0, then 32 requests. Required: rkey_out = 0xA5000000..0xA500001F, idx 0..31, last only on idx 31. A 33rd request returns 0xA5000000 with idx 0.
- Decryption read: core_blk_start with dec_mode=1, then 32 requests. Required: 0xA500001F down to 0xA5000000, idx 0..31, last on the final key.
- Early request: requests while LOADING (after 10 beats). Required: no rkey_out_vld. Loading then completes correctly.
- Overrun and reload: a 33rd vld beat sets key_err=1 and leaves stored keys unchanged. Then key_load_start in the same cycle as a request. Required: no vld, keys_ready=0 and key_err=0 next cycle. Reload with 0x5A000000+i reads back the new values.
- Reset mid-operation: assert sys_rst_n=0 during a read burst at idx 12. Required: all outputs 0 immediately. After release, requests give no vld until a full reload.
